// File: rtl/fib_stream_checker.sv
// rtl/fib_stream_checker.sv - Fibonacci stream checker: seeds from two words, checks recurrence, measures period
module fib_stream_checker #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             match,
   output logic             mismatch,
   output logic             locked,
   output logic [WIDTH-1:0] expected,
   output logic [CNT_W-1:0] word_count,
   output logic [CNT_W-1:0] err_count,
   output logic             err_seen,
   output logic [CNT_W-1:0] first_err_idx,
   output logic             period_valid,
   output logic [CNT_W-1:0] period
);

   localparam logic [1:0] SEED_A = 2'd0;
   localparam logic [1:0] SEED_B = 2'd1;
   localparam logic [1:0] TRACK  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       state_q, state_d;
   logic             ready_q, ready_d;
   logic [WIDTH-1:0] seed0_q, seed0_d;
   logic [WIDTH-1:0] seed1_q, seed1_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] cur_q, cur_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic             match_q, match_d;
   logic             mismatch_q, mismatch_d;
   logic [CNT_W-1:0] wc_q, wc_d;
   logic [CNT_W-1:0] ec_q, ec_d;
   logic             err_seen_q, err_seen_d;
   logic [CNT_W-1:0] fei_q, fei_d;
   logic             pv_q, pv_d;
   logic [CNT_W-1:0] period_q, period_d;

   logic xfer;
   logic word_eq;
   logic period_hit;

   // clear blocks acceptance in its own cycle so no word slips past a restart
   assign in_ready   = ready_q & ~clear;
   assign xfer       = in_valid & in_ready;
   // exp_q already holds prev+cur, so the compare needs no adder in its path
   assign word_eq    = (in_data == exp_q);
   assign period_hit = (wc_q >= CNT_W'(3)) && (cur_q == seed0_q) && (in_data == seed1_q);

   assign match         = match_q;
   assign mismatch      = mismatch_q;
   assign locked        = (state_q == TRACK);
   assign expected      = exp_q;
   assign word_count    = wc_q;
   assign err_count     = ec_q;
   assign err_seen      = err_seen_q;
   assign first_err_idx = fei_q;
   assign period_valid  = pv_q;
   assign period        = period_q;

   // next-state: seeding, recurrence check, statistics and period capture
   always_comb begin
      state_d    = state_q;
      ready_d    = 1'b1;
      seed0_d    = seed0_q;
      seed1_d    = seed1_q;
      prev_d     = prev_q;
      cur_d      = cur_q;
      exp_d      = exp_q;
      match_d    = 1'b0;
      mismatch_d = 1'b0;
      wc_d       = wc_q;
      ec_d       = ec_q;
      err_seen_d = err_seen_q;
      fei_d      = fei_q;
      pv_d       = pv_q;
      period_d   = period_q;

      if (clear) begin
         state_d    = SEED_A;
         seed0_d    = '0;
         seed1_d    = '0;
         prev_d     = '0;
         cur_d      = '0;
         exp_d      = '0;
         wc_d       = '0;
         ec_d       = '0;
         err_seen_d = 1'b0;
         fei_d      = '0;
         pv_d       = 1'b0;
         period_d   = '0;
      end else if (xfer) begin
         if (wc_q != CNT_MAX) begin
            wc_d = wc_q + CNT_W'(1);
         end
         case (state_q)
            SEED_A: begin
               seed0_d = in_data;
               prev_d  = in_data;
               state_d = SEED_B;
            end
            SEED_B: begin
               seed1_d = in_data;
               cur_d   = in_data;
               exp_d   = prev_q + in_data;
               state_d = TRACK;
            end
            TRACK: begin
               match_d    = word_eq;
               mismatch_d = ~word_eq;
               if (!word_eq) begin
                  if (ec_q != CNT_MAX) begin
                     ec_d = ec_q + CNT_W'(1);
                  end
                  if (!err_seen_q) begin
                     err_seen_d = 1'b1;
                     fei_d      = wc_q;
                  end
               end
               // follow the received stream so one bad word costs one mismatch
               prev_d = cur_q;
               cur_d  = in_data;
               exp_d  = cur_q + in_data;
               if (period_hit && !pv_q) begin
                  pv_d     = 1'b1;
                  period_d = wc_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = SEED_A;
            end
         endcase
      end
   end

   // state registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SEED_A;
         ready_q    <= 1'b0;
         seed0_q    <= '0;
         seed1_q    <= '0;
         prev_q     <= '0;
         cur_q      <= '0;
         exp_q      <= '0;
         match_q    <= 1'b0;
         mismatch_q <= 1'b0;
         wc_q       <= '0;
         ec_q       <= '0;
         err_seen_q <= 1'b0;
         fei_q      <= '0;
         pv_q       <= 1'b0;
         period_q   <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         seed0_q    <= seed0_d;
         seed1_q    <= seed1_d;
         prev_q     <= prev_d;
         cur_q      <= cur_d;
         exp_q      <= exp_d;
         match_q    <= match_d;
         mismatch_q <= mismatch_d;
         wc_q       <= wc_d;
         ec_q       <= ec_d;
         err_seen_q <= err_seen_d;
         fei_q      <= fei_d;
         pv_q       <= pv_d;
         period_q   <= period_d;
      end
   end

endmodule

// File: doc/fib_stream_checker.md
# fib_stream_checker

Receive-side companion to the team's 8-bit Fibonacci sequence generator. It accepts a stream of words over a valid/ready handshake and seeds itself from the first two words. It then checks every later word against the recurrence x[n] = x[n-1] + x[n-2] mod 2^WIDTH, and reports per-word match/mismatch pulses, error statistics and the measured sequence period. It sits on the generator's output, as a self-check monitor in simulation or on the board.

## Interface
- WIDTH, 8, data word width; the recurrence wraps mod 2^WIDTH
- CNT_W, 16, width of all counters and indices
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous restart; same effect as reset, applied on the clock edge
- in_valid  in  1  in_data is presented
- in_data  in  WIDTH  sequence word
- in_ready  out  1  checker can accept a word
- match  out  1  one-cycle pulse: the checked word equalled its prediction
- mismatch  out  1  one-cycle pulse: the checked word differed from its prediction
- locked  out  1  both seed words have been taken and checking is active
- expected  out  WIDTH  prediction for the next word; meaningful only while locked
- word_count  out  CNT_W  number of accepted words; saturating
- err_count  out  CNT_W  number of mismatches; saturating
- err_seen  out  1  sticky flag: at least one mismatch has occurred
- first_err_idx  out  CNT_W  0-based index of the first mismatching word
- period_valid  out  1  sticky flag: a period has been measured
- period  out  CNT_W  measured period, in words

## Operation
- **Transfer rule:** a transfer occurs on a rising edge where in_valid=1 and in_ready=1.
- **in_ready:**
  - 0 during reset.
  - 1 from the first edge after rst_n deasserts.
  - Forced 0 in any cycle where clear=1.
- **State machine:** SEED_A, then SEED_B, then TRACK.
  - SEED_A: a transfer stores seed0 = in_data and prev = in_data. Next state SEED_B. No pulse.
  - SEED_B: a transfer stores seed1 = in_data and cur = in_data. Next state TRACK. No pulse.
  - TRACK: each transfer compares in_data with expected = (prev + cur) mod 2^WIDTH. The carry is discarded.
    - Equal: match pulses.
    - Different: mismatch pulses; err_count increments.
    - On the first mismatch: err_seen sets and first_err_idx = word_count (the index of this word).
    - Both cases then shift prev <= cur and cur <= in_data. The checker follows the received stream, so it resynchronises after a single corrupted word.
- **Index:** the word accepted while word_count = i has index i. word_count increments on every transfer and saturates at 2^CNT_W-1. err_count saturates the same way.
- **Period detection** applies in TRACK to a word with index i ≥ 3.
  - Condition: cur == seed0 and in_data == seed1.
  - Action: latch period = i-1 and set period_valid.
  - Only the first occurrence is latched; later recurrences are ignored.
  - Example: for seeds 1,1 at WIDTH=8, period = 384.
- **locked:** equals (state == TRACK).
- **clear / reset:**
  - Return to SEED_A.
  - Zero every counter, index and sticky flag.
  - Drop match and mismatch.
  - A word presented in the same cycle as clear is not accepted.

## Timing
- **Reset values:** in_ready=0; match=0; mismatch=0; locked=0; expected=0; word_count=0; err_count=0; err_seen=0; first_err_idx=0; period_valid=0; period=0.
- **Pulse latency:** match and mismatch are registered. They are high for exactly the one cycle after the transfer edge and are never high together.
- **Counter and flag latency:** word_count, err_count, err_seen, first_err_idx, period and period_valid update on the transfer edge and are visible in the following cycle.
- **expected:** registered; it reflects the updated prev and cur one cycle after each transfer.
- **Throughput:** back-to-back transfers, one word per cycle, with no bubbles.
- **Asynchronous reset mid-stream:** takes effect immediately; any pulse in flight is cancelled.
- **Held words:** in_valid=0 cycles leave all state unchanged, and in_data is ignored.

## Test plan
- **Reset values:** hold rst_n=0 for 3 cycles, then release. Required: all outputs at their reset values; in_ready=1 from the first edge after release; locked=0.
- **Clean start:** stream 1,1,2,3,5,8,13 back-to-back. Required: locked=1 after the second word; 5 match pulses; 0 mismatch pulses; word_count=7; expected=21.
- **Wrap-around:** seed 144,233, then send 121. Required: a match pulse, because 377 mod 256 = 121; expected then equals 98.
- **Single-word error:** stream 1,1,2,4,6,10.
  - The word 4 gives a mismatch pulse, err_count=1, first_err_idx=3.
  - The words 6 and 10 give match pulses (resync).
  - err_seen stays 1.
- **Period measurement:** stream 386 Fibonacci words mod 256 from seeds 1,1. Required: period_valid=1 and period=384; no mismatches.
- **clear and reset mid-stream:**
  - Assert clear while in_valid=1 mid-stream. Required: that word is not accepted; state returns to SEED_A; counters read 0; the next two words re-seed.
  - Repeat with rst_n pulsed low asynchronously. Required: the same result.
